apb_req_arbiter: RTL
====================

// Module: apb_req_arbiter
// PURPOSE
//  APB bus master that shares one APB slave port between NUM_REQ local requesters.
//  Arbitrates with a round-robin policy and sequences the IDLE/SETUP/ACCESS phases.
//  Handles pready wait states and aborts hung transfers with a timeout.
//  Sits between the bridge-side request agents and the APB slave fabric
//  (paddr/pwdata/pwrite/psel/penable out; prdata/pready in).
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=1)
//  APB_ADDR_W  32  paddr width
//  APB_BUS_W   32  pwdata/prdata width
//  TIMEOUT     16  max ACCESS cycles with pready low before abort; 0 = never abort
// PORTS
//  clk        in   1                    single clock, all logic on posedge
//  reset      in   1                    synchronous, active-high reset
//  req_valid  in   NUM_REQ              per-requester transfer request, held until accepted
//  req_write  in   NUM_REQ              1 = write, 0 = read
//  req_addr   in   NUM_REQ*APB_ADDR_W   packed; requester i at [i*APB_ADDR_W +: APB_ADDR_W]
//  req_wdata  in   NUM_REQ*APB_BUS_W    packed, same layout
//  req_ready  out  NUM_REQ              one-hot accept; request i taken when valid[i]&ready[i]
//  rsp_valid  out  NUM_REQ              one-hot, one-cycle completion pulse to owner
//  rsp_rdata  out  APB_BUS_W            read data, valid with rsp_valid (0 for writes/errors)
//  rsp_err    out  1                    1 with rsp_valid when transfer aborted by timeout
//  paddr      out  APB_ADDR_W           APB address
//  pwdata     out  APB_BUS_W            APB write data
//  pwrite     out  1                    APB direction
//  psel       out  1                    APB select
//  penable    out  1                    APB enable
//  prdata     in   APB_BUS_W            APB read data
//  pready     in   1                    APB ready / wait-state extension
// BEHAVIOUR
//  - Reset values: state=IDLE; psel, penable, pwrite, req_ready, rsp_valid and rsp_err = 0.
//    paddr, pwdata and rsp_rdata = 0. Round-robin pointer = NUM_REQ-1, so req 0 has first priority.
//  - FSM states are IDLE, SETUP and ACCESS. psel=1 in SETUP and ACCESS. penable=1 in ACCESS only.
//  - IDLE:
//    - req_ready is combinational from the state and req_valid.
//    - If any req_valid is high, grant the first set bit searching upward from pointer+1
//      (wrap-around at NUM_REQ). Assert req_ready[g] in that cycle only.
//    - Latch addr/wdata/write of g into paddr/pwdata/pwrite and set pointer = g.
//    - Next state is SETUP.
//  - SETUP: lasts exactly 1 cycle, then ACCESS. The wait counter is cleared.
//  - ACCESS:
//    - pready=1 sampled: capture prdata (reads only), pulse rsp_valid[g] next cycle, go IDLE.
//    - pready=0: increment the wait counter.
//    - Counter == TIMEOUT (TIMEOUT>0): abort and go IDLE. Next cycle pulses rsp_valid[g]
//      with rsp_err=1 and rsp_rdata=0.
//  - Latency with zero wait states:
//    - T0 accept (IDLE), T1 SETUP, T2 ACCESS with pready=1, T3 rsp_valid in IDLE.
//    - Every wait cycle adds 1.
//  - paddr/pwdata/pwrite stay stable from SETUP through the last ACCESS cycle and hold
//    their last value in IDLE.
//  - The IDLE cycle carrying rsp_valid may grant a new request in the same cycle, including
//    from the same requester. Sustained throughput is 1 transfer per 3 cycles.
//  - req_valid dropping before accept is legal: no grant. Changes to a non-granted
//    requester's inputs are ignored.
//  - Reset mid-transfer: the next cycle is IDLE with psel=penable=0. No rsp_valid is
//    issued for the aborted transfer.
//  - NUM_REQ=1: the pointer is constant and behaviour is otherwise identical.
// TESTING
//  1. Single read, req0 addr=0x10, pready=1 in the 1st ACCESS, prdata=0xCAFEF00D
//     -> psel at T1, penable at T2; rsp_valid[0] at T3 with rsp_rdata=0xCAFEF00D, rsp_err=0.
//  2. Write req1 addr=0x24 wdata=0x5A5A5A5A, pready low for 3 cycles
//     -> ACCESS lasts 4 cycles with paddr/pwdata stable; rsp_valid[1] 1 cycle after pready.
//  3. req0 and req1 both valid continuously after reset
//     -> grants alternate 0,1,0,1; each new grant coincides with the previous rsp_valid cycle.
//  4. TIMEOUT=16, pready stuck at 0
//     -> after 16 ACCESS cycles psel/penable drop; rsp_valid=1, rsp_err=1, rsp_rdata=0;
//        the next request proceeds normally.
//  5. Assert reset during ACCESS of a read
//     -> psel=penable=0 next cycle, no rsp_valid, pointer=NUM_REQ-1 (req0 wins next arbitration).
//  6. NUM_REQ=4, only req3 and req1 valid, pointer=1
//     -> req3 granted first, then req1 (upward search with wrap-around).

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Round-robin APB master: shares one APB slave port among NUM_REQ local requesters,
// sequences IDLE/SETUP/ACCESS, honours pready wait states and aborts hung transfers.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int APB_ADDR_W = 32,
  parameter int APB_BUS_W  = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*APB_BUS_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [APB_BUS_W-1:0]          rsp_rdata,
  output logic                          rsp_err,
  output logic [APB_ADDR_W-1:0]         paddr,
  output logic [APB_BUS_W-1:0]          pwdata,
  output logic                          pwrite,
  output logic                          psel,
  output logic                          penable,
  input  logic [APB_BUS_W-1:0]          prdata,
  input  logic                          pready,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a request i is taken in the cycle req_valid[i] & req_ready[i]; the requester
  // holds valid (and its data) until then. rsp_valid is a one-cycle pulse with no backpressure.

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_X = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [APB_ADDR_W-1:0]  paddr_q, paddr_d;
  logic [APB_BUS_W-1:0]   pwdata_q, pwdata_d;
  logic                   pwrite_q, pwrite_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [APB_BUS_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                   grant_found;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W:0]         cand;
  logic                   timeout_hit;

  // Search upward from pointer+1 with wrap-around; the pointer itself is checked last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (cand >= NUM_REQ_X) cand = cand - NUM_REQ_X;
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          ptr_d    = grant_idx;
          paddr_d  = req_addr[int'(grant_idx) * APB_ADDR_W +: APB_ADDR_W];
          pwdata_d = req_wdata[int'(grant_idx) * APB_BUS_W +: APB_BUS_W];
          pwrite_d = req_write[grant_idx];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        // ptr_q still names the owner here; it only moves on the next grant.
        if (pready) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : prdata;
          state_d            = ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d[ptr_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
          state_d            = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RST;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign dbg_state = state_q;

endmodule
